// File: rtl/pq_window_stats.sv
// pq_window_stats: windowed statistics over sign-magnitude samples from the
// constant-gain scaling multiplier. Each window of 2^LOG2_WIN accepted
// samples yields peak magnitude, mean absolute value, signed mean (floor)
// and a saturating zero-crossing count, published as a registered snapshot
// with a one-cycle stats_valid pulse.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   in_data[23:0] sample, bit 23 = sign (1 = negative), bits 22:0 = magnitude
//   in_valid      one-cycle accept strobe
//   clear         synchronous window restart (discards partial window)
//   peak_out      max magnitude of last completed window
//   mean_abs_out  sum of magnitudes >> LOG2_WIN
//   dc_out        signed sum >>> LOG2_WIN, low 24 bits, two's complement
//   zc_count      saturating sign-change count of last completed window
//   stats_valid   one-cycle pulse when the outputs update
module pq_window_stats #(
    parameter int unsigned LOG2_WIN = 8,
    parameter int unsigned ZC_W     = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [23:0]     in_data,
    input  logic            in_valid,
    input  logic            clear,
    output logic [22:0]     peak_out,
    output logic [22:0]     mean_abs_out,
    output logic [23:0]     dc_out,
    output logic [ZC_W-1:0] zc_count,
    output logic            stats_valid
);

    localparam int unsigned AW  = 23 + LOG2_WIN;
    localparam int unsigned SW  = 24 + LOG2_WIN;
    localparam int unsigned CW  = LOG2_WIN + 1;
    localparam int unsigned WIN = 2 ** LOG2_WIN;
    localparam logic [ZC_W-1:0] ZC_MAX = '1;

    typedef enum logic {
        IDLE_ACC = 1'b0,
        PUBLISH  = 1'b1
    } state_t;

    state_t state, state_nxt;
    logic   pub_c;

    logic [AW-1:0]   abs_sum;
    logic [SW-1:0]   sgn_sum;
    logic [22:0]     peak;
    logic [CW-1:0]   cnt;
    logic [ZC_W-1:0] zc;
    logic            last_valid;
    logic            last_neg;

    logic [22:0]     snap_peak;
    logic [22:0]     snap_mean;
    logic [23:0]     snap_dc;
    logic [ZC_W-1:0] snap_zc;

    logic [22:0]     mag_c;
    logic            nz_c;
    logic            neg_c;
    logic            win_done_c;
    logic [SW-1:0]   sval_c;
    logic [AW-1:0]   abs_nxt_c;
    logic [SW-1:0]   sgn_nxt_c;
    logic [22:0]     peak_nxt_c;
    logic [ZC_W-1:0] zc_nxt_c;

    // Sample decode; negative zero folds to plain zero
    assign mag_c  = in_data[22:0];
    assign nz_c   = |mag_c;
    assign neg_c  = in_data[23] & nz_c;
    assign sval_c = neg_c ? (SW'(0) - SW'(mag_c)) : SW'(mag_c);

    // Running totals including the current sample
    assign abs_nxt_c  = abs_sum + AW'(mag_c);
    assign sgn_nxt_c  = sgn_sum + sval_c;
    assign peak_nxt_c = (mag_c > peak) ? mag_c : peak;
    assign zc_nxt_c   = (nz_c && last_valid && (neg_c != last_neg) && (zc != ZC_MAX))
                        ? zc + ZC_W'(1) : zc;

    // The sample being accepted closes the window
    assign win_done_c = in_valid && !clear && (cnt == CW'(WIN - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE_ACC;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; PUBLISH always lasts a single cycle
    always_comb begin
        state_nxt = state;
        pub_c     = 1'b0;
        case (state)
            IDLE_ACC: begin
                if (win_done_c) begin
                    state_nxt = PUBLISH;
                end
            end
            PUBLISH: begin
                pub_c     = 1'b1;
                state_nxt = IDLE_ACC;
            end
        endcase
    end

    // Accumulators, sign tracking and window snapshot; runs in both states
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abs_sum    <= '0;
            sgn_sum    <= '0;
            peak       <= '0;
            cnt        <= '0;
            zc         <= '0;
            last_valid <= 1'b0;
            last_neg   <= 1'b0;
            snap_peak  <= '0;
            snap_mean  <= '0;
            snap_dc    <= '0;
            snap_zc    <= '0;
        end else if (clear) begin
            abs_sum    <= '0;
            sgn_sum    <= '0;
            peak       <= '0;
            cnt        <= '0;
            zc         <= '0;
            last_valid <= 1'b0;
        end else if (in_valid) begin
            // Last sign survives window boundaries
            if (nz_c) begin
                last_valid <= 1'b1;
                last_neg   <= neg_c;
            end
            if (win_done_c) begin
                snap_peak <= peak_nxt_c;
                snap_mean <= abs_nxt_c[AW-1:LOG2_WIN];
                snap_dc   <= sgn_nxt_c[SW-1:LOG2_WIN];
                snap_zc   <= zc_nxt_c;
                abs_sum   <= '0;
                sgn_sum   <= '0;
                peak      <= '0;
                cnt       <= '0;
                zc        <= '0;
            end else begin
                abs_sum <= abs_nxt_c;
                sgn_sum <= sgn_nxt_c;
                peak    <= peak_nxt_c;
                cnt     <= cnt + CW'(1);
                zc      <= zc_nxt_c;
            end
        end
    end

    // Published outputs hold until the next PUBLISH cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_out     <= '0;
            mean_abs_out <= '0;
            dc_out       <= '0;
            zc_count     <= '0;
            stats_valid  <= 1'b0;
        end else begin
            stats_valid <= pub_c;
            if (pub_c) begin
                peak_out     <= snap_peak;
                mean_abs_out <= snap_mean;
                dc_out       <= snap_dc;
                zc_count     <= snap_zc;
            end
        end
    end

endmodule

// File: tb/tb_pq_window_stats.sv
// Bench for pq_window_stats: two instances (ZC_W=16 and ZC_W=1) share the
// same stimulus; a queue-based window model predicts every output cycle.
module tb_pq_window_stats;

    localparam int unsigned L   = 2;
    localparam int          WIN = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        clear = 1'b0;

    logic [22:0] peak_out, mean_abs_out, peak_b, mean_b;
    logic [23:0] dc_out, dc_b;
    logic [15:0] zc_count;
    logic [0:0]  zc_b;
    logic        stats_valid, valid_b;

    always #5 clk = ~clk;

    pq_window_stats #(.LOG2_WIN(L), .ZC_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .clear(clear), .peak_out(peak_out), .mean_abs_out(mean_abs_out),
        .dc_out(dc_out), .zc_count(zc_count), .stats_valid(stats_valid)
    );

    pq_window_stats #(.LOG2_WIN(L), .ZC_W(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .clear(clear), .peak_out(peak_b), .mean_abs_out(mean_b),
        .dc_out(dc_b), .zc_count(zc_b), .stats_valid(valid_b)
    );

    int n_cmp = 0;
    int n_err = 0;
    int pulses = 0;

    // Reference model state
    int q_mag[$];
    int q_sgn[$];
    bit have_last, last_neg, pend;
    int zcnt;
    int p_peak, p_mean, p_dc, p_zc;
    bit e_valid;
    int e_peak, e_mean, e_dc, e_zc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_mag.delete();
        q_sgn.delete();
        have_last = 0; last_neg = 0; pend = 0; zcnt = 0;
        e_valid = 0; e_peak = 0; e_mean = 0; e_dc = 0; e_zc = 0;
    endtask

    // One rising edge of behaviour at window/statistics level
    task automatic model_step(input logic [23:0] d, input bit v, input bit c);
        int mag, sa, ss, mx;
        bit neg;
        e_valid = pend;
        if (pend) begin
            e_peak = p_peak; e_mean = p_mean; e_dc = p_dc; e_zc = p_zc;
        end
        pend = 0;
        if (c) begin
            q_mag.delete(); q_sgn.delete();
            have_last = 0; zcnt = 0;
        end else if (v) begin
            mag = int'(d[22:0]);
            neg = d[23] && (mag != 0);
            q_mag.push_back(mag);
            q_sgn.push_back(neg ? -mag : mag);
            if (mag != 0) begin
                if (have_last && (neg != last_neg)) zcnt++;
                have_last = 1;
                last_neg = neg;
            end
            if (q_mag.size() == WIN) begin
                sa = 0; ss = 0; mx = 0;
                foreach (q_mag[i]) begin
                    sa += q_mag[i];
                    ss += q_sgn[i];
                    if (q_mag[i] > mx) mx = q_mag[i];
                end
                p_peak = mx;
                p_mean = sa / WIN;
                p_dc = ss / WIN;
                if ((ss % WIN != 0) && (ss < 0)) p_dc = p_dc - 1;
                p_zc = zcnt;
                pend = 1;
                q_mag.delete(); q_sgn.delete();
                zcnt = 0;
            end
        end
    endtask

    task automatic check_all();
        logic [23:0] dcx;
        dcx = 24'(e_dc);
        chk("stats_valid", 32'(stats_valid), 32'(e_valid));
        chk("peak", 32'(peak_out), 32'(e_peak));
        chk("mean_abs", 32'(mean_abs_out), 32'(e_mean));
        chk("dc", 32'(dc_out), 32'(dcx));
        chk("zc", 32'(zc_count), 32'((e_zc > 65535) ? 65535 : e_zc));
        chk("zc_sat", 32'(zc_b), 32'((e_zc > 1) ? 1 : e_zc));
    endtask

    task automatic cycle(input logic [23:0] d, input bit v, input bit c);
        @(negedge clk);
        in_data = d; in_valid = v; clear = c;
        @(posedge clk);
        model_step(d, v, c);
        #1;
        if (stats_valid) pulses++;
        check_all();
    endtask

    task automatic send_spaced(input logic [23:0] d);
        cycle(d, 1'b1, 1'b0);
        repeat (3) cycle(24'h0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset asserted mid-cycle
    task automatic do_reset();
        @(negedge clk);
        in_valid = 0; clear = 0;
        rst_n = 0;
        model_reset();
        #1 check_all();
        @(posedge clk);
        #1 check_all();
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        logic [23:0] d;
        int r;
        model_reset();
        do_reset();

        // Alternating +/-100, spaced accepts
        cycle(24'h000064, 1, 0); cycle(0, 0, 0); cycle(0, 0, 0); cycle(0, 0, 0);
        cycle(24'h800064, 1, 0); cycle(0, 0, 0); cycle(0, 0, 0); cycle(0, 0, 0);
        cycle(24'h000064, 1, 0); cycle(0, 0, 0); cycle(0, 0, 0); cycle(0, 0, 0);
        cycle(24'h800064, 1, 0);
        cycle(0, 0, 0);
        chk("p1_valid", 32'(stats_valid), 32'd1);
        chk("p1_peak", 32'(peak_out), 32'd100);
        chk("p1_mean", 32'(mean_abs_out), 32'd100);
        chk("p1_dc", 32'(dc_out), 32'd0);
        chk("p1_zc", 32'(zc_count), 32'd3);
        cycle(0, 0, 0);
        chk("p1_pulse_len", 32'(stats_valid), 32'd0);
        cycle(0, 0, 0);

        // Cross-window crossing from the prior negative sample
        send_spaced(24'h000004); send_spaced(24'h000004); send_spaced(24'h000004);
        cycle(24'h000008, 1, 0);
        cycle(0, 0, 0);
        chk("p2_peak", 32'(peak_out), 32'd8);
        chk("p2_mean", 32'(mean_abs_out), 32'd5);
        chk("p2_dc", 32'(dc_out), 32'd5);
        chk("p2_zc", 32'(zc_count), 32'd1);
        repeat (2) cycle(0, 0, 0);

        // Negative values with negative zero, floor of -3/4
        do_reset();
        send_spaced(24'h800001); send_spaced(24'h800001); send_spaced(24'h800001);
        cycle(24'h800000, 1, 0);
        cycle(0, 0, 0);
        chk("p3_peak", 32'(peak_out), 32'd1);
        chk("p3_mean", 32'(mean_abs_out), 32'd0);
        chk("p3_dc", 32'(dc_out), 32'hFFFFFF);
        chk("p3_zc", 32'(zc_count), 32'd0);
        repeat (2) cycle(0, 0, 0);

        // Back-to-back accepts through PUBLISH
        pulses = 0;
        repeat (12) cycle(24'h000010, 1, 0);
        repeat (3) cycle(0, 0, 0);
        chk("b2b_pulses", 32'(pulses), 32'd3);
        chk("b2b_mean", 32'(mean_abs_out), 32'd16);
        chk("b2b_dc", 32'(dc_out), 32'd16);

        // Clear with simultaneous valid discards partial window
        cycle(24'h000050, 1, 0); cycle(24'h800033, 1, 0);
        cycle(24'h000099, 1, 1);
        chk("clr_hold_peak", 32'(peak_out), 32'd16);
        pulses = 0;
        repeat (4) cycle(24'h000002, 1, 0);
        cycle(0, 0, 0);
        chk("clr_mean", 32'(mean_abs_out), 32'd2);
        chk("clr_peak", 32'(peak_out), 32'd2);
        chk("clr_zc", 32'(zc_count), 32'd0);
        repeat (2) cycle(0, 0, 0);
        chk("clr_pulses", 32'(pulses), 32'd1);

        // Reset mid-window
        repeat (3) cycle(24'h800020, 1, 0);
        do_reset();
        repeat (4) cycle(24'h000007, 1, 0);
        cycle(0, 0, 0);
        chk("rst_mean", 32'(mean_abs_out), 32'd7);
        chk("rst_zc", 32'(zc_count), 32'd0);

        // Reset while in PUBLISH suppresses the pulse
        repeat (4) cycle(24'h000009, 1, 0);
        do_reset();
        pulses = 0;
        repeat (3) cycle(0, 0, 0);
        chk("pubrst_pulses", 32'(pulses), 32'd0);

        // Alternating signs saturate the 1-bit counter
        repeat (4) begin
            cycle(24'h000003, 1, 0);
            cycle(24'h800003, 1, 0);
        end
        repeat (2) cycle(0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 7));
            case (r)
                0: d = 24'h800000;
                1: d = 24'h000000;
                2: d = 24'($urandom);
                default: d = {1'($urandom), 23'($urandom_range(1, 15))};
            endcase
            if ($urandom_range(0, 199) == 0) do_reset();
            cycle(d, $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
        end
        repeat (3) cycle(0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pq_window_stats.md
Name: pq_window_stats

Overview:
- Downstream consumer of the constant-gain scaling multiplier. Takes its 24-bit sign-magnitude result and one-cycle `done` strobe.
- Over a window of 2^LOG2_WIN samples it computes:
  - peak magnitude
  - mean absolute value
  - signed mean (DC offset, two's complement)
  - zero-crossing count
- Publishes all four as a registered snapshot with a one-cycle valid pulse, for the power-quality decision logic.

Parameters:
- LOG2_WIN, 8, window length = 2^LOG2_WIN samples (legal range 1..16)
- ZC_W, 16, width of zero-crossing counter output

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_data  in  24  sample: bit 23 = sign (1 = negative), bits 22:0 = magnitude
- in_valid  in  1  one-cycle strobe, sample accepted on the edge where high (driven by the multiplier's done)
- clear  in  1  synchronous window restart
- peak_out  out  23  max magnitude in last completed window
- mean_abs_out  out  23  sum of magnitudes >> LOG2_WIN, truncated
- dc_out  out  24  two's-complement signed sum >>> LOG2_WIN, floor toward -inf
- zc_count  out  ZC_W  sign changes in last completed window, saturating
- stats_valid  out  1  one-cycle pulse when outputs update

Behaviour:
- Reset (rst_n low, async):
  - all outputs 0
  - accumulators, sample counter and peak are 0
  - last-sign-valid flag is 0
  - pipeline state is IDLE_ACC
- Sample decode:
  - mag = in_data[22:0]
  - sign-magnitude to two's complement: signed = sign ? -mag : +mag, sign-extended to 24+LOG2_WIN bits
  - Negative zero (0x800000) is treated as zero: contributes 0, never a crossing, never updates last sign.
- Accumulators:
  - abs_sum is 23+LOG2_WIN bits; cannot overflow
  - sgn_sum is 24+LOG2_WIN bits, signed
  - peak updates when mag > peak
  - sample counter is LOG2_WIN+1 bits
- Zero crossing:
  - On each nonzero sample: if the flag is set and the sign differs from the stored last sign, the count increments, saturating at 2^ZC_W-1.
  - Every nonzero sample then stores its sign and sets the flag.
  - Last sign persists across window boundaries. It is cleared only by reset or clear.
- State machine (two states):
  - IDLE_ACC: accumulating.
    - On the accept edge of sample number 2^LOG2_WIN (edge E0), the window totals including that sample are latched into snapshot registers.
    - On that same edge, all accumulators, peak, zc and the counter reset to 0 and the machine enters PUBLISH.
  - PUBLISH: lasts exactly one cycle.
    - At edge E1 the output registers load the snapshot values: mean_abs = abs_sum >> LOG2_WIN, dc = arithmetic shift, low 24 bits.
    - stats_valid is high for the cycle after E1, then low. Return to IDLE_ACC.
- Throughput:
  - One sample per cycle is sustained, including in PUBLISH.
  - A sample arriving at E0+1 (in PUBLISH) counts as sample 1 of the new window. No sample is ever dropped.
- Outputs hold their values until the next publish.
- clear:
  - Zeroes accumulators, peak, counter, zc and the last-sign flag; the partial window is discarded.
  - Outputs are not changed.
  - clear together with in_valid: clear wins and the sample is discarded.
  - clear in PUBLISH: the publish still completes, since the snapshot is already latched.
- Reset mid-window or mid-publish: immediate return to the reset state; no stats_valid is emitted.

Test Plan:
- LOG2_WIN=2, after reset, in_data 0x000064, 0x800064, 0x000064, 0x800064 with valid spaced 4 cycles -> one stats_valid pulse 2 edges after the last accept: peak=100, mean_abs=100, dc=0, zc=3.
- Continue with 0x000004, 0x000004, 0x000004, 0x000008 -> peak=8, mean_abs=5, dc=5, zc=1 (crossing from the prior window's negative sample).
- After reset: 0x800001, 0x800001, 0x800001, 0x800000 -> peak=1, mean_abs=0, dc=0xFFFFFF (-1, floor), zc=0; negative zero adds no crossing.
- Back-to-back in_valid every cycle for 12 samples of 0x000010 -> exactly 3 stats_valid pulses, each with mean_abs=16, dc=16, peak=16, zc=0; no sample lost across PUBLISH.
- Two samples, then clear asserted with a simultaneous valid, then 4 samples of 0x000002 -> single publish with mean_abs=2, peak=2; outputs are unchanged by the clear.
- rst_n pulsed low after 3 of 4 samples, then 4 samples of 0x000007 -> no pulse before the reset; all outputs read 0 during reset; next publish is mean_abs=7, zc=0.
